mdriver_arbiter: RTL

Round-robin arbiter and sequencer that shares one `master_wrapper` bus master between `NREQ` requesters. Each requester posts a single read or write (address plus write data). The arbiter picks one requester and drives the master's request port, holding it stable until the master acknowledges. It then returns read data and a completion pulse to the winning requester. It sits between the requesters and the master's slave-side request port.

---
 rtl/mdriver_arb_pkg.sv | 13 +
 rtl/mdriver_rr_pick.sv | 43 ++++
 rtl/mdriver_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mdriver_arb_pkg.sv
// Shared types and default widths for the mdriver round-robin arbiter.
package mdriver_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam int ARB_DW = 32;
   localparam int ARB_AW = 8;

endpackage

// File: rtl/mdriver_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mdriver_rr_pick
   import mdriver_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [IW-1:0]   pick_idx,
   output logic            any
);

   logic [IW:0]   sum;
   logic [IW-1:0] j;

   // scan offsets 0..NREQ-1 from ptr, keeping the first hit
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      any      = 1'b0;
      sum      = '0;
      j        = '0;
      for (int off = 0; off < NREQ; off++) begin
         sum = {1'b0, ptr} + (IW+1)'(off);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end else begin
            sum = sum;
         end
         j = sum[IW-1:0];
         if (!any && req[j]) begin
            any      = 1'b1;
            pick_idx = j;
            pick[j]  = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/mdriver_arbiter.sv
// Round-robin arbiter/sequencer sharing one bus master among NREQ requesters.
// Optional BUSY timeout abort is enabled by defining SERUM_ARB_TIMEOUT_EN.
module mdriver_arbiter
   import mdriver_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = ARB_DW,
   parameter int AW      = ARB_AW,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]  gnt,
   output logic [NREQ-1:0]  done,
   output logic [DW-1:0]    rdata,
   output logic             err,
   output logic             busy,
   output logic             m_req,
   output logic             m_we,
   output logic [AW-1:0]    m_addr,
   output logic [DW-1:0]    m_wdata,
   input  logic             m_ack,
   input  logic [DW-1:0]    m_rdata
);

   localparam int IW = $clog2(NREQ);

   arb_state_t      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic            m_we_q, m_we_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_wdata_q, m_wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            m_req_q, m_req_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;

   logic [NREQ-1:0] pick;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            tmo;

   mdriver_rr_pick #(.NREQ(NREQ)) u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (pick_any)
   );

`ifdef SERUM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // cycle counter runs only in BUSY, so it is zero on every BUSY entry
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   // timeout counter register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   // next-state and next-output decode; outputs are flopped from next state
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d   = BUSY;
               idx_d     = pick_idx;
               m_we_d    = we[pick_idx];
               m_addr_d  = addr[int'(pick_idx)*AW +: AW];
               m_wdata_d = wdata[int'(pick_idx)*DW +: DW];
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // m_ack wins over a same-cycle timeout
            if (m_ack) begin
               state_d = DONE;
               if (!m_we_q) begin
                  rdata_d = m_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (tmo) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (idx_q == IW'(NREQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = (state_d != IDLE);
      m_req_d = (state_d == BUSY);
      gnt_d   = '0;
      done_d  = '0;
      if (busy_d) begin
         gnt_d[idx_d] = 1'b1;
      end else begin
         gnt_d = '0;
      end
      if (state_d == DONE) begin
         done_d[idx_d] = 1'b1;
      end else begin
         done_d = '0;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         ptr_q     <= '0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         m_req_q   <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         m_req_q   <= m_req_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign busy    = busy_q;
   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule
